// File: rtl/seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// seq_gen_pkg
// Shared types and constants for the Moore serial pattern generator.
//   state_e                 : FSM state encoding (IDLE is always 0)
//   SEQ_GEN_DEFAULT_PATTERN : the 4-bit pattern the companion detector matches
// Optional macro SEQ_GEN_PARITY_EN adds the PARITY state encoding.
// -----------------------------------------------------------------------------
package seq_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND   = 3'd1,
    ST_GAP    = 3'd2,
`ifdef SEQ_GEN_PARITY_EN
    ST_DONE   = 3'd3,
    ST_PARITY = 3'd4
`else
    ST_DONE   = 3'd3
`endif
  } state_e;

  localparam logic [3:0] SEQ_GEN_DEFAULT_PATTERN = 4'b1011;

endpackage : seq_gen_pkg

// File: rtl/seq_gen_shifter.sv
// -----------------------------------------------------------------------------
// seq_gen_shifter
// Pattern register plus bit-index counter for the serial generator.
//   clock, reset_n : clock, asynchronous active-low reset
//   load           : capture load_val and restart the index at PATTERN_W-1
//   shift          : advance to the next bit (MSB first)
//   load_val       : pattern to capture on load
//   bit_next       : bit that will be current after this edge (feeds the
//                    parent's registered serial output)
//   last_bit       : the current bit is bit 0 of the pattern
// -----------------------------------------------------------------------------
module seq_gen_shifter #(
  parameter int PATTERN_W = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic [PATTERN_W-1:0] load_val,
  output logic                 bit_next,
  output logic                 last_bit
);

  localparam int IDX_W = $clog2(PATTERN_W);

  logic [PATTERN_W-1:0] sh_q, sh_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    if (load) begin
      sh_d  = load_val;
      idx_d = IDX_W'(PATTERN_W - 1);
    end else if (shift) begin
      // Rotate rather than shift in zero: the MSB is always the current bit,
      // and the register contents are never needed beyond one pass.
      sh_d  = {sh_q[PATTERN_W-2:0], sh_q[PATTERN_W-1]};
      idx_d = idx_q - IDX_W'(1);
    end
  end

  assign bit_next = sh_d[PATTERN_W-1];
  assign last_bit = (idx_q == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
    end
  end

endmodule : seq_gen_shifter

// File: rtl/sequence_generator_moore.sv
// -----------------------------------------------------------------------------
// sequence_generator_moore
// Moore-FSM serial pattern transmitter. On start it sends `pattern` MSB first,
// repeat_count times (0 treated as 1), with gap_cycles idle cycles between
// frames, then pulses done.
//   clock, reset_n : clock, asynchronous active-low reset
//   start          : transmit request, honoured only when idle
//   pattern        : bits to send, MSB first
//   repeat_count   : number of frames
//   gap_cycles     : idle cycles between frames (0 = back-to-back)
//   sequence_out   : registered serial data
//   frame          : sequence_out carries a pattern/parity bit
//   busy           : transmission in progress (through the done cycle)
//   done           : one-cycle completion pulse
// Optional macro SEQ_GEN_PARITY_EN appends an odd-parity bit to every frame.
// -----------------------------------------------------------------------------
module sequence_generator_moore
  import seq_gen_pkg::*;
#(
  parameter int PATTERN_W = 4,
  parameter int REPEAT_W  = 4,
  parameter int GAP_W     = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [REPEAT_W-1:0]  repeat_count,
  input  logic [GAP_W-1:0]     gap_cycles,
  output logic                 sequence_out,
  output logic                 frame,
  output logic                 busy,
  output logic                 done
);

  state_e               state_q, state_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [REPEAT_W-1:0]  frames_q, frames_d;
  logic [GAP_W-1:0]     gap_len_q, gap_len_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 seq_out_q, seq_out_d;
  logic                 frame_q, frame_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 sh_load, sh_shift, bit_next, last_bit;
  logic [PATTERN_W-1:0] load_val;
  logic                 frame_end;

  seq_gen_shifter #(
    .PATTERN_W (PATTERN_W)
  ) u_shifter (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (sh_load),
    .shift    (sh_shift),
    .load_val (load_val),
    .bit_next (bit_next),
    .last_bit (last_bit)
  );

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    frames_d  = frames_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    frame_end = 1'b0;
    // Fresh pattern comes from the port only on acceptance; reloads between
    // frames use the latched copy so the host may change inputs freely.
    load_val  = (state_q == ST_IDLE) ? pattern : pat_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SEND;
          pat_d     = pattern;
          frames_d  = (repeat_count == '0) ? REPEAT_W'(1) : repeat_count;
          gap_len_d = gap_cycles;
          sh_load   = 1'b1;
        end
      end
      ST_SEND: begin
        if (!last_bit) begin
          sh_shift = 1'b1;
        end else begin
`ifdef SEQ_GEN_PARITY_EN
          state_d = ST_PARITY;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      ST_PARITY: frame_end = 1'b1;
`endif
      ST_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d   = ST_SEND;
          sh_load   = 1'b1;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Frame boundary: count the frame off (never below zero) and pick the
    // next phase.
    if (frame_end) begin
      if (frames_q > REPEAT_W'(1)) begin
        frames_d = frames_q - REPEAT_W'(1);
        if (gap_len_q != '0) begin
          state_d   = ST_GAP;
          gap_cnt_d = gap_len_q;
        end else begin
          state_d = ST_SEND;
          sh_load = 1'b1;
        end
      end else begin
        frames_d = '0;
        state_d  = ST_DONE;
      end
    end

    // Outputs are registered from the next state so they line up with it.
    seq_out_d = (state_d == ST_SEND) ? bit_next : 1'b0;
`ifdef SEQ_GEN_PARITY_EN
    if (state_d == ST_PARITY) seq_out_d = ~(^pat_q);
    frame_d = (state_d == ST_SEND) || (state_d == ST_PARITY);
`else
    frame_d = (state_d == ST_SEND);
`endif
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      frames_q  <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      seq_out_q <= 1'b0;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      frames_q  <= frames_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      seq_out_q <= seq_out_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sequence_out = seq_out_q;
  assign frame        = frame_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule : sequence_generator_moore

// File: tb/tb_sequence_generator_moore.sv
// -----------------------------------------------------------------------------
// tb_sequence_generator_moore
// Directed bench: each transmission pushes its expected per-cycle output
// vector {sequence_out, frame, busy, done} into a queue; every cycle one entry
// is popped and compared (empty queue means idle, all zero). A small 1011
// window counter stands in for the detector.
// -----------------------------------------------------------------------------
module tb_sequence_generator_moore;
  import seq_gen_pkg::*;

  localparam int PATTERN_W = 4;
  localparam int REPEAT_W  = 4;
  localparam int GAP_W     = 4;
`ifdef SEQ_GEN_PARITY_EN
  localparam int PW_EFF = PATTERN_W + 1;
`else
  localparam int PW_EFF = PATTERN_W;
`endif

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 start;
  logic [PATTERN_W-1:0] pattern;
  logic [REPEAT_W-1:0]  repeat_count;
  logic [GAP_W-1:0]     gap_cycles;
  logic                 sequence_out, frame, busy, done;

  always #5 clock = ~clock;

  sequence_generator_moore #(
    .PATTERN_W (PATTERN_W),
    .REPEAT_W  (REPEAT_W),
    .GAP_W     (GAP_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .pattern      (pattern),
    .repeat_count (repeat_count),
    .gap_cycles   (gap_cycles),
    .sequence_out (sequence_out),
    .frame        (frame),
    .busy         (busy),
    .done         (done)
  );

  logic [3:0] exp_q[$];
  int         n_checks = 0;
  int         n_err    = 0;
  logic [3:0] det_sh;
  int         hits;

  // Wait one active edge, then compare the outputs against the next
  // expected vector.
  task automatic step_check(input string tag);
    logic [3:0] exp_v, got;
    @(posedge clock);
    #1;
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
    got   = {sequence_out, frame, busy, done};
    n_checks++;
    assert (got === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b (seq,frame,busy,done)", tag, got, exp_v);
    end
    det_sh = {det_sh[2:0], sequence_out};
    if (det_sh == SEQ_GEN_DEFAULT_PATTERN) hits++;
  endtask

  // Reference model of one complete transmission.
  task automatic push_model(input logic [PATTERN_W-1:0] pat,
                            input logic [REPEAT_W-1:0]  rc,
                            input logic [GAP_W-1:0]     gap);
    int n;
    n = (rc == 0) ? 1 : int'(rc);
    for (int f = 0; f < n; f++) begin
      for (int b = PATTERN_W - 1; b >= 0; b--) exp_q.push_back({pat[b], 3'b110});
`ifdef SEQ_GEN_PARITY_EN
      exp_q.push_back({~(^pat), 3'b110});
`endif
      if (f < n - 1) begin
        for (int g = 0; g < int'(gap); g++) exp_q.push_back(4'b0010);
      end
    end
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
  endtask

  // One transmission. pulse_a/pulse_b: step index (edge E+i) at which a
  // stray start is presented; -1 for none. exp_hits < 0 skips detector check.
  task automatic send(input logic [PATTERN_W-1:0] pat,
                      input logic [REPEAT_W-1:0]  rc,
                      input logic [GAP_W-1:0]     gap,
                      input int pulse_a, input int pulse_b,
                      input int exp_hits, input string tag);
    pattern      = pat;
    repeat_count = rc;
    gap_cycles   = gap;
    start        = 1'b1;
    det_sh       = 4'b0000;
    hits         = 0;
    push_model(pat, rc, gap);
    step_check(tag);
    start        = 1'b0;
    pattern      = ~pat;
    repeat_count = REPEAT_W'($urandom_range(0, 15));
    gap_cycles   = GAP_W'($urandom_range(0, 15));
    for (int i = 1; exp_q.size() > 0 && i < 500; i++) begin
      start = (i == pulse_a) || (i == pulse_b);
      step_check(tag);
    end
    start = 1'b0;
    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL %s_drain: observed %0d pending expected 0", tag, exp_q.size());
    end
    if (exp_hits >= 0) begin
      n_checks++;
      assert (hits == exp_hits) else begin
        n_err++;
        $error("FAIL %s_hits: observed %0d expected %0d", tag, hits, exp_hits);
      end
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    pattern      = '0;
    repeat_count = '0;
    gap_cycles   = '0;
    det_sh       = 4'b0000;
    hits         = 0;

    // Reset held, then released with no start: stays idle.
    repeat (3) step_check("reset");
    #2 reset_n = 1'b1;
    repeat (10) step_check("idle");

    send(4'b1011, 4'd1, 4'd0, -1, -1, 1, "single");
    send(4'b1011, 4'd3, 4'd2, -1, -1, 3, "r3g2");
    send(4'b1011, 4'd1, 4'd0, 2, PW_EFF + 1, 1, "ign_start");
    send(4'b1011, 4'd2, 4'd0, -1, -1, 2, "b2b");
    send(4'b0110, 4'd2, 4'd1, -1, -1, -1, "r2g1");
    send(4'b1100, 4'd0, 4'd3, -1, -1, -1, "rc0");
    send(4'b1010, 4'd2, 4'd15, -1, -1, -1, "gapmax");

    // Reset dropped during the second bit of a frame.
    pattern      = 4'b1011;
    repeat_count = 4'd3;
    gap_cycles   = 4'd2;
    start        = 1'b1;
    push_model(4'b1011, 4'd3, 4'd2);
    step_check("mid_b3");
    start = 1'b0;
    step_check("mid_b2");
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    assert ({sequence_out, frame, busy, done} === 4'b0000) else begin
      n_err++;
      $error("FAIL async_rst: observed %b expected 0000", {sequence_out, frame, busy, done});
    end
    exp_q.delete();
    repeat (2) step_check("in_rst");
    #2 reset_n = 1'b1;
    repeat (3) step_check("post_rst");
    send(4'b1011, 4'd1, 4'd0, -1, -1, 1, "fresh");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_sequence_generator_moore
